// File: rtl/majority_sample_window_pkg.sv
// Shared types for the majority-voter front end: the FSM state and the five-vote bundle
// that is handed from the sampler to the voter.
package majority_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int NUM_VOTES = 5;

    typedef logic [NUM_VOTES-1:0] vote_vec_t;

    // Phase within the bit period at which vote k is captured.
    function automatic int sample_phase(input int first, input int spacing, input int k);
        return first + k * spacing;
    endfunction

endpackage

// File: rtl/majority_sample_window_if.sv
// Valid/ready window bundle between the oversampling front end and the majority voter.
interface majority_sample_window_if;
    import majority_pkg::*;

    vote_vec_t win;
    logic      win_valid;
    logic      win_ready;

    modport master (
        output win,
        output win_valid,
        input  win_ready
    );

    modport slave (
        input  win,
        input  win_valid,
        output win_ready
    );

endinterface

// File: rtl/majority_sample_window_bit_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level, cleared by the async reset.
module bit_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/majority_sample_window.sv
// Oversampling front end: captures five samples per serial bit period and offers each
// completed window to the voter under valid/ready, flagging windows lost to back-pressure.
module majority_sample_window
    import majority_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 16,
    parameter int FIRST_SAMPLE   = 4,
    parameter int SAMPLE_SPACING = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            din,
    majority_sample_window_if.master        win_bus,
    output logic                            overrun,
    output logic                            bit_tick
);

    localparam int                  PHASE_W    = $clog2(CLKS_PER_BIT);
    localparam logic [PHASE_W-1:0]  LAST_PHASE = PHASE_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
            $error("majority_sample_window: CLKS_PER_BIT must be at least 8");
        end
        if (SAMPLE_SPACING < 1) begin : g_bad_spacing
            $error("majority_sample_window: SAMPLE_SPACING must be at least 1");
        end
        if (FIRST_SAMPLE < 0) begin : g_bad_first
            $error("majority_sample_window: FIRST_SAMPLE must not be negative");
        end
        if (FIRST_SAMPLE + (NUM_VOTES - 1) * SAMPLE_SPACING > CLKS_PER_BIT - 1) begin : g_bad_window
            $error("majority_sample_window: last sample falls outside the bit period");
        end
    endgenerate

    logic               din_s;
    state_e             state;
    state_e             state_next;
    logic [PHASE_W-1:0] phase;
    vote_vec_t          partial;
    vote_vec_t          partial_next;
    vote_vec_t          sample_hit;
    vote_vec_t          win_q;
    logic               win_valid_q;
    logic               run_edge;
    logic               complete;

    bit_sync2 u_din_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (en)  state_next = RUN;
            RUN:     if (!en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A sample landing on the completion edge is folded into the window being loaded.
    always_comb begin
        run_edge     = (state == RUN) && en;
        complete     = run_edge && (phase == LAST_PHASE);
        sample_hit   = '0;
        partial_next = partial;
        for (int k = 0; k < NUM_VOTES; k++) begin
            sample_hit[k] = run_edge &&
                (phase == PHASE_W'(sample_phase(FIRST_SAMPLE, SAMPLE_SPACING, k)));
            if (sample_hit[k]) begin
                partial_next[k] = din_s;
            end
        end
    end

    // Leaving RUN (or sitting in IDLE) discards any half-collected window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= '0;
            partial <= '0;
        end else if (run_edge) begin
            phase   <= (phase == LAST_PHASE) ? '0 : phase + PHASE_W'(1);
            partial <= partial_next;
        end else begin
            phase   <= '0;
            partial <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q       <= '0;
            win_valid_q <= 1'b0;
            overrun     <= 1'b0;
            bit_tick    <= 1'b0;
        end else begin
            bit_tick <= complete;
            overrun  <= complete && win_valid_q && !win_bus.win_ready;
            if (complete) begin
                if (!win_valid_q || win_bus.win_ready) begin
                    win_q       <= partial_next;
                    win_valid_q <= 1'b1;
                end
            end else if (win_valid_q && win_bus.win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign win_bus.win       = win_q;
    assign win_bus.win_valid = win_valid_q;

endmodule

// File: tb/tb_majority_sample_window.sv
// Self-checking bench for majority_sample_window: directed bit-period tables, hand-built
// corner sequences and randomized traffic against a per-edge behavioural model.
module tb_majority_sample_window;
    import majority_pkg::*;

    localparam int CPB = 16;
    localparam int FS  = 4;
    localparam int SP  = 2;

    typedef struct {
        logic [CPB-1:0] pattern;
        logic [4:0]     expected;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic din;
    logic overrun;
    logic bit_tick;

    majority_sample_window_if win_if ();

    majority_sample_window #(
        .CLKS_PER_BIT   (CPB),
        .FIRST_SAMPLE   (FS),
        .SAMPLE_SPACING (SP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (din),
        .win_bus  (win_if.master),
        .overrun  (overrun),
        .bit_tick (bit_tick)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Behavioural model state: position counts edges into the current bit period.
    bit         m_run;
    int         m_pos;
    bit         m_part [NUM_VOTES];
    logic [4:0] m_win;
    bit         m_valid;
    bit         m_ovr;
    bit         m_tick;
    bit         m_hist [$];

    task automatic modelReset();
        m_run   = 1'b0;
        m_pos   = 0;
        foreach (m_part[i]) m_part[i] = 1'b0;
        m_win   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_tick  = 1'b0;
        m_hist  = '{1'b0, 1'b0};
    endtask

    // The line seen by the sampler is din from two edges earlier.
    task automatic modelEdge(input bit en_v, input bit din_v, input bit ready_v);
        bit s;
        bit done;
        int slot;
        s = m_hist.pop_front();
        m_hist.push_back(din_v);
        done   = 1'b0;
        m_tick = 1'b0;
        m_ovr  = 1'b0;
        if (!m_run) begin
            if (en_v) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (!en_v) begin
            m_run = 1'b0;
            m_pos = 0;
            foreach (m_part[i]) m_part[i] = 1'b0;
        end else begin
            if (m_pos >= FS && ((m_pos - FS) % SP) == 0) begin
                slot = (m_pos - FS) / SP;
                if (slot < NUM_VOTES) m_part[slot] = s;
            end
            if (m_pos == CPB - 1) begin
                done   = 1'b1;
                m_tick = 1'b1;
                if (!m_valid || ready_v) begin
                    for (int k = 0; k < NUM_VOTES; k++) m_win[k] = m_part[k];
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            m_pos = (m_pos + 1) % CPB;
        end
        if (!done && m_valid && ready_v) m_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] ew, input logic ev,
                               input logic eo, input logic et);
        n_compared++;
        if (win_if.win !== ew || win_if.win_valid !== ev || overrun !== eo || bit_tick !== et) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got win=%b valid=%b overrun=%b tick=%b, expected win=%b valid=%b overrun=%b tick=%b",
                     name, $time, win_if.win, win_if.win_valid, overrun, bit_tick, ew, ev, eo, et);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive at the falling edge, clock once, then compare against the model.
    task automatic applyStimulus(input bit en_v, input bit din_v, input bit ready_v);
        en               = en_v;
        din              = din_v;
        win_if.win_ready = ready_v;
        @(posedge clk);
        modelEdge(en_v, din_v, ready_v);
        @(negedge clk);
        checkOutput("model", m_win, m_valid, m_ovr, m_tick);
    endtask

    // One bit period from phase 0; pattern[p] is what the sampler sees at phase p.
    task automatic runPeriod(input logic [CPB-1:0] pattern, input logic [CPB-1:0] ready_mask);
        for (int p = 0; p < CPB; p++) begin
            applyStimulus(1'b1, pattern[(p + 2) % CPB], ready_mask[p]);
        end
    endtask

    task automatic measureFirstValid(output int edges);
        edges = 0;
        for (int e = 1; e <= 40; e++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (win_if.win_valid === 1'b1) begin
                edges = e;
                break;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [8];
        int   first_edges;
        int   ticks;
        int   first_tick;
        int   ovrs;

        vecs[0] = '{16'hFFFF, 5'b11111};
        vecs[1] = '{16'hFEFF, 5'b11011};
        vecs[2] = '{16'h0010, 5'b00001};
        vecs[3] = '{16'hAAAA, 5'b00000};
        vecs[4] = '{16'h1000, 5'b10000};
        vecs[5] = '{16'h0440, 5'b01010};
        vecs[6] = '{16'h1510, 5'b11101};
        vecs[7] = '{16'hEFEF, 5'b01110};

        modelReset();
        rst              = 1'b1;
        en               = 1'b0;
        din              = 1'b0;
        win_if.win_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset state", 5'b00000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        $display("[TB] startup with din held high");
        measureFirstValid(first_edges);
        checkValue("first valid edge", first_edges, CPB + 1);
        checkOutput("startup window", 5'b11111, 1'b1, 1'b0, 1'b1);

        ticks      = 0;
        first_tick = 0;
        ovrs       = 0;
        for (int i = 1; i <= 2 * CPB; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (bit_tick === 1'b1) begin
                ticks++;
                if (first_tick == 0) first_tick = i;
            end
            if (overrun === 1'b1) ovrs++;
        end
        checkValue("tick count", ticks, 2);
        checkValue("tick spacing", first_tick, CPB);
        checkValue("overrun count", ovrs, 0);

        $display("[TB] window table");
        for (int v = 0; v < 8; v++) begin
            runPeriod(vecs[v].pattern, 16'hFFFF);
            checkOutput($sformatf("table %0d", v), vecs[v].expected, 1'b1, 1'b0, 1'b1);
        end

        $display("[TB] back-pressure and simultaneous accept");
        runPeriod(16'h1110, 16'h0001);
        checkOutput("bp first window", 5'b10101, 1'b1, 1'b0, 1'b1);
        runPeriod(16'h0440, 16'h0000);
        checkOutput("bp overrun", 5'b10101, 1'b1, 1'b1, 1'b1);
        runPeriod(16'hFFFF, 16'h8000);
        checkOutput("simultaneous accept", 5'b11111, 1'b1, 1'b0, 1'b1);
        runPeriod(16'h0010, 16'h0001);
        checkOutput("after consume", 5'b00001, 1'b1, 1'b0, 1'b1);

        $display("[TB] enable drop on completion edge");
        for (int p = 0; p < CPB - 1; p++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("drop at completion", 5'b00001, 1'b1, 1'b0, 1'b0);

        $display("[TB] enable drop mid-period");
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int p = 0; p < 7; p++) applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        runPeriod(16'h0400, 16'hFFFF);
        checkOutput("fresh window after drop", 5'b01000, 1'b1, 1'b0, 1'b1);

        $display("[TB] reset mid-run");
        for (int p = 0; p < 9; p++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        checkOutput("pre-reset held", 5'b01000, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("reset mid-run", 5'b00000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        measureFirstValid(first_edges);
        checkValue("restart valid edge", first_edges, CPB + 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 63) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 63) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/majority_sample_window.md
# majority_sample_window

Front-end stage for the 5-input majority voter. It oversamples a serial input line and captures five samples near the middle of each bit period. Each completed window is presented as a 5-bit vector under a valid/ready handshake, so the voter can resolve every bit from five votes. The block owns bit timing, input synchronisation and back-pressure; the voter downstream stays purely combinational.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit period; minimum 8.
- FIRST_SAMPLE, default 4: phase of sample 0 within the bit period.
- SAMPLE_SPACING, default 2: phase distance between consecutive samples, minimum 1.
- Legality constraint: FIRST_SAMPLE + 4*SAMPLE_SPACING <= CLKS_PER_BIT-1. Elaboration fails otherwise.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  run enable, level-sensitive.
- din  in  1  raw serial line, asynchronous to clk.
- win  out  5  sample window: win[0]=pa (earliest sample) … win[4]=pe (latest).
- win_valid  out  1  win holds an unconsumed window.
- win_ready  in  1  consumer accepts win this cycle.
- overrun  out  1  one-cycle pulse: a completed window was dropped.
- bit_tick  out  1  one-cycle pulse at the end of every bit period.

## Operation
- Sample input: din passes through a 2-flop synchroniser. All samples use the synchronised value din_s.
- States: IDLE and RUN.
  - IDLE → RUN on an edge with en=1; phase is loaded with 0.
  - RUN → IDLE on any edge with en=0. Phase and the partial sample register are cleared. A pending win/win_valid is retained.
- Phase counter: width clog2(CLKS_PER_BIT). It increments every RUN edge and wraps from CLKS_PER_BIT-1 to 0.
- Sampling: at the RUN edge where phase == FIRST_SAMPLE + k*SAMPLE_SPACING (k=0..4), partial[k] <= din_s.
- Completion: at the RUN edge where phase == CLKS_PER_BIT-1, bit_tick pulses and the partial window completes.
  - If win_valid=0, or win_valid=1 with win_ready=1, then win <= partial and win_valid <= 1.
  - Otherwise, win and win_valid are unchanged and overrun pulses for one cycle.
- Consume: win_valid=1 and win_ready=1 with no completion on that edge → win_valid <= 0. win keeps its old value.
- win_ready while win_valid=0 has no effect.
- Reset, at any time: state=IDLE, phase=0, partial=0, win=5'b00000, win_valid=0, overrun=0, bit_tick=0. Synchroniser flops are 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- din → din_s latency is 2 edges.
- For default parameters, samples are taken at phases 4, 6, 8, 10, 12 and completion at phase 15.
- The first win_valid rises CLKS_PER_BIT+1 edges after the first edge that samples en=1. Subsequent windows arrive every CLKS_PER_BIT edges.
- Simultaneous completion and accept on the same edge: the new window loads, win_valid stays 1, and overrun=0.
- If en drops on the completion edge, the transition to IDLE wins. No window is loaded and bit_tick does not pulse.
- win is stable for as long as win_valid=1 and win_ready=0.

## Structure
- Package majority_pkg holds:
  - state_e enum {IDLE, RUN};
  - localparam NUM_VOTES=5;
  - typedef logic [NUM_VOTES-1:0] vote_vec_t, shared with the voter as its pa..pe bundle.
- Sub-module bit_sync2: generic 2-flop synchroniser with asynchronous active-high reset, instantiated once for din.
- The phase counter, FSM and output register live in the top module.

## Test plan
- Reset mid-run: assert rst at phase 9 with win_valid=1 → all outputs 0 within the same cycle; after release, a restart needs 17 edges to the next win_valid.
- Defaults, win_ready tied 1, din constant 1, en held high → win=5'b11111 and win_valid first at edge 17, then bit_tick every 16 edges, overrun never asserted.
- Glitch capture: din_s pattern putting 0 only at phase 8 → win=5'b11011 (pa=1, pb=1, pc=0, pd=1, pe=1).
- Back-pressure: win_ready=0 for two bit periods → first window held unchanged, overrun pulses once at the second completion edge, and the second window is lost.
- Simultaneous: win_ready=1 exactly on a completion edge with win_valid=1 → win updates to the new window, win_valid stays high, overrun=0.
- Enable drop: en=0 at phase 7 then en=1 again → the partial window is discarded and the next window reflects only fresh samples at phases 4..12 of the new period.
